// File: rtl/piso_pkg.sv
// Shared constants and helpers for the piso serializer and its benches.
// Optional status outputs are enabled with the PISO_STATUS_EN macro.
package piso_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Width of a counter able to hold every value from 0 up to and including width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_if.sv
// Parallel load / serial output bundle for piso. The bits_left and empty
// status members exist only when PISO_STATUS_EN is defined.
interface piso_if
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             load;
  logic [WIDTH-1:0] parallel_in;
  logic             shift;
  logic             serial_out;

`ifdef PISO_STATUS_EN
  logic [cnt_width(WIDTH)-1:0] bits_left;
  logic                        empty;

  modport master (
    output load,
    output parallel_in,
    output shift,
    input  serial_out,
    input  bits_left,
    input  empty
  );

  modport slave (
    input  load,
    input  parallel_in,
    input  shift,
    output serial_out,
    output bits_left,
    output empty
  );
`else
  modport master (
    output load,
    output parallel_in,
    output shift,
    input  serial_out
  );

  modport slave (
    input  load,
    input  parallel_in,
    input  shift,
    output serial_out
  );
`endif

endinterface

// File: rtl/piso_bit_counter.sv
// Loadable down-counter tracking how many serialized bits remain; it
// saturates at zero so over-shifting never wraps around.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic                        dec,
  output logic [cnt_width(WIDTH)-1:0] count,
  output logic                        empty
);

  localparam int CW = cnt_width(WIDTH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(WIDTH);
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign empty = (count == '0);

endmodule

// File: rtl/piso.sv
// Parallel-in, serial-out shift register, MSB first, with registered output.
// Define PISO_STATUS_EN to build the bits_left / empty status counter.
module piso
  import piso_pkg::*;
#(
  parameter int   WIDTH    = DEFAULT_WIDTH,
  parameter logic FILL_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  piso_if.slave bus
);

  logic [WIDTH-1:0] sreg;

  // Load wins over shift; the MSB flop feeds serial_out with no logic after it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg <= '0;
    end else if (bus.load) begin
      sreg <= bus.parallel_in;
    end else if (bus.shift) begin
      sreg <= {sreg[WIDTH-2:0], FILL_BIT};
    end
  end

  assign bus.serial_out = sreg[WIDTH-1];

`ifdef PISO_STATUS_EN
  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .load  (bus.load),
    .dec   (bus.shift),
    .count (bus.bits_left),
    .empty (bus.empty)
  );
`endif

endmodule

// File: tb/tb_piso.sv
// Randomized scoreboard bench for piso; expected outputs come from a
// word-plus-position reference model, checked by an independent monitor.
module tb_piso;
  import piso_pkg::*;

  localparam int   W    = DEFAULT_WIDTH;
  localparam int   CW   = cnt_width(W);
  localparam logic FILL = 1'b0;

  typedef struct packed {
    logic          ser;
    logic [CW-1:0] left;
    logic          emp;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  piso_if #(.WIDTH(W)) bus ();

  piso #(
    .WIDTH    (W),
    .FILL_BIT (FILL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: last captured word plus number of shifts since capture.
  logic [W-1:0] m_word;
  int           m_k;
  bit           m_valid;

  function automatic exp_t model_out();
    exp_t e;
    e.ser  = (m_k < W) ? m_word[W-1-m_k] : FILL;
    e.left = m_valid ? CW'(W - m_k) : '0;
    e.emp  = (e.left == '0);
    return e;
  endfunction

  task automatic model_reset();
    m_word  = '0;
    m_k     = 0;
    m_valid = 1'b0;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_state(input string tag, input exp_t e);
    check_output({tag, ".serial_out"}, 64'(bus.serial_out), 64'(e.ser));
`ifdef PISO_STATUS_EN
    check_output({tag, ".bits_left"}, 64'(bus.bits_left), 64'(e.left));
    check_output({tag, ".empty"}, 64'(bus.empty), 64'(e.emp));
`endif
  endtask

  // Monitor: one expectation per driven cycle, compared just after the edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_state("cycle", e);
    end
  end

  task automatic apply_stimulus(input logic l, input logic [W-1:0] pin, input logic s);
    @(negedge clk);
    bus.load        = l;
    bus.parallel_in = pin;
    bus.shift       = s;
    if (l) begin
      m_word  = pin;
      m_k     = 0;
      m_valid = 1'b1;
    end else if (s) begin
      if (m_k < W) m_k++;
    end
    exp_q.push_back(model_out());
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    bus.load        = 1'b1;
    bus.parallel_in = '1;
    bus.shift       = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    #1 check_state("async_reset", model_out());
    exp_q.push_back(model_out());
    @(negedge clk);
    reset    = 1'b1;
    bus.load = 1'b0;
    exp_q.push_back(model_out());
  endtask

  task automatic load_then_shift(input logic [W-1:0] pin, input int n);
    apply_stimulus(1'b1, pin, 1'b0);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, W'($urandom), 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    reset           = 1'b0;
    bus.load        = 1'b0;
    bus.parallel_in = '0;
    bus.shift       = 1'b0;
    model_reset();
    #12;
    check_state("power_on_reset", model_out());
    @(negedge clk);
    reset = 1'b1;

    reset_pulse();

    load_then_shift(8'b1100_1100, 9);

    apply_stimulus(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, W'($urandom), 1'b0);

    apply_stimulus(1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < W; i++) apply_stimulus(1'b0, '0, 1'b1);

    load_then_shift(8'hFF, W + 3);

    load_then_shift(8'hF0, 2);
    reset_pulse();
    apply_stimulus(1'b1, 8'h80, 1'b0);
    apply_stimulus(1'b0, '0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) reset_pulse();
      else apply_stimulus(r < 15, W'($urandom), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    @(negedge clk);
    check_output("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
